// File: rtl/sercfg_receiver.sv
// -----------------------------------------------------------------------------
// sercfg_receiver
//
// Chip-side receiver for the four-wire serial configuration link. The link
// pins are oversampled in the clkin domain. A fixed-length frame of
// 8*NREGS bits is shifted in MSB-first, reg1 first. On a capture strobe the
// frame is transferred into the parallel shadow bank that feeds the TDC core.
// A capture after any bit count other than 8*NREGS leaves the bank unchanged
// and raises the sticky len_err flag.
//
// Optional feature macro: SERCFG_READBACK_EN
//   When defined, sdo presents the MSB of the shift register (registered).
//   This lets the previous frame be read back or daisy-chained.
//
// Ports:
//   clkin      system clock, all logic on posedge
//   rst        synchronous active-high reset
//   s_sck      link shift clock (async)
//   s_sda      link data (async)
//   s_scapt    link capture strobe (async)
//   s_reset    link reset, active-high (async)
//   cfg_data   shadow bank, reg1 in the top byte, regN in the bottom byte
//   cfg_valid  one-cycle pulse when cfg_data has just been updated
//   len_err    sticky: the last capture saw a wrong bit count
//   busy       at least one bit shifted since the last capture/reset
//   sdo        readback data (SERCFG_READBACK_EN only)
// -----------------------------------------------------------------------------
module sercfg_receiver #(
    parameter int NREGS       = 13,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clkin,
    input  logic                 rst,
    input  logic                 s_sck,
    input  logic                 s_sda,
    input  logic                 s_scapt,
    input  logic                 s_reset,
    output logic [8*NREGS-1:0]   cfg_data,
    output logic                 cfg_valid,
    output logic                 len_err,
`ifdef SERCFG_READBACK_EN
    output logic                 busy,
    output logic                 sdo
`else
    output logic                 busy
`endif
);

    localparam int FB = 8 * NREGS;
    // Counter saturates one past a full frame so over-length frames stay flagged.
    localparam int CW = $clog2(FB + 2);
    localparam logic [CW-1:0] FRAME_CNT = CW'(FB);
    localparam logic [CW-1:0] SAT_CNT   = CW'(FB + 1);
    localparam logic [CW-1:0] ONE_CNT   = CW'(1);
    localparam logic [CW-1:0] ZERO_CNT  = CW'(0);

    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic [SYNC_STAGES-1:0] capt_sync_r;
    logic [SYNC_STAGES-1:0] lrst_sync_r;
    logic                   sck_prev_r;
    logic                   capt_prev_r;

    logic                   sck_rise_s;
    logic                   capt_rise_s;
    logic                   sda_s;
    logic                   lrst_s;

    logic [FB-1:0]          sr_r;
    logic [FB-1:0]          sr_n_s;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_n_s;
    logic [FB-1:0]          cfg_data_r;
    logic [FB-1:0]          cfg_data_n_s;
    logic                   cfg_valid_r;
    logic                   cfg_valid_n_s;
    logic                   len_err_r;
    logic                   len_err_n_s;
    logic                   busy_r;
    logic                   busy_n_s;

    // Synchronizer chains plus the edge-detect history flops for sck/scapt.
    always_ff @(posedge clkin) begin
        if (rst) begin
            sck_sync_r  <= {SYNC_STAGES{1'b0}};
            sda_sync_r  <= {SYNC_STAGES{1'b0}};
            capt_sync_r <= {SYNC_STAGES{1'b0}};
            lrst_sync_r <= {SYNC_STAGES{1'b0}};
            sck_prev_r  <= 1'b0;
            capt_prev_r <= 1'b0;
        end else begin
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], s_sck};
            sda_sync_r  <= {sda_sync_r[SYNC_STAGES-2:0], s_sda};
            capt_sync_r <= {capt_sync_r[SYNC_STAGES-2:0], s_scapt};
            lrst_sync_r <= {lrst_sync_r[SYNC_STAGES-2:0], s_reset};
            sck_prev_r  <= sck_sync_r[SYNC_STAGES-1];
            capt_prev_r <= capt_sync_r[SYNC_STAGES-1];
        end
    end

    // sda is taken from the same stage as sck so both see identical latency.
    assign sda_s       = sda_sync_r[SYNC_STAGES-1];
    assign lrst_s      = lrst_sync_r[SYNC_STAGES-1];
    assign sck_rise_s  = sck_sync_r[SYNC_STAGES-1] & ~sck_prev_r;
    assign capt_rise_s = capt_sync_r[SYNC_STAGES-1] & ~capt_prev_r;

    // Next-state for frame assembly and capture. Capture reads the pre-shift
    // sr/cnt; a coincident shift then starts the next frame with one bit.
    always_comb begin
        sr_n_s        = sr_r;
        cnt_n_s       = cnt_r;
        cfg_data_n_s  = cfg_data_r;
        cfg_valid_n_s = 1'b0;
        len_err_n_s   = len_err_r;
        busy_n_s      = busy_r;

        if (capt_rise_s) begin
            if (cnt_r == FRAME_CNT) begin
                cfg_data_n_s  = sr_r;
                cfg_valid_n_s = 1'b1;
                len_err_n_s   = 1'b0;
            end else begin
                cfg_data_n_s  = cfg_data_r;
                cfg_valid_n_s = 1'b0;
                len_err_n_s   = 1'b1;
            end
            cnt_n_s  = ZERO_CNT;
            busy_n_s = 1'b0;
        end else begin
            cnt_n_s  = cnt_r;
            busy_n_s = busy_r;
        end

        if (sck_rise_s) begin
            sr_n_s   = {sr_r[FB-2:0], sda_s};
            busy_n_s = 1'b1;
            if (capt_rise_s) begin
                cnt_n_s = ONE_CNT;
            end else if (cnt_r == SAT_CNT) begin
                cnt_n_s = SAT_CNT;
            end else begin
                cnt_n_s = cnt_r + ONE_CNT;
            end
        end else begin
            sr_n_s = sr_r;
        end
    end

    // Frame state registers; rst and the link reset have identical effect.
    always_ff @(posedge clkin) begin
        if (rst || lrst_s) begin
            sr_r        <= {FB{1'b0}};
            cnt_r       <= ZERO_CNT;
            cfg_data_r  <= {FB{1'b0}};
            cfg_valid_r <= 1'b0;
            len_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            sr_r        <= sr_n_s;
            cnt_r       <= cnt_n_s;
            cfg_data_r  <= cfg_data_n_s;
            cfg_valid_r <= cfg_valid_n_s;
            len_err_r   <= len_err_n_s;
            busy_r      <= busy_n_s;
        end
    end

    assign cfg_data  = cfg_data_r;
    assign cfg_valid = cfg_valid_r;
    assign len_err   = len_err_r;
    assign busy      = busy_r;

`ifdef SERCFG_READBACK_EN
    logic sdo_r;

    // Readback flop tracks the MSB the shift register will hold after this cycle.
    always_ff @(posedge clkin) begin
        if (rst || lrst_s) begin
            sdo_r <= 1'b0;
        end else begin
            sdo_r <= sr_n_s[FB-1];
        end
    end

    assign sdo = sdo_r;
`endif

endmodule
